// File: rtl/if_row_packer.sv
// rtl/if_row_packer.sv - packs a tagged element stream into IF FIFO words
// Elements carry {row_start, row_end, data}; one FIFO write per IF_PAR_WRITE elements.
module if_row_packer #(
  parameter int IF_SCRATCH_WIDTH = 16,
  parameter int IF_PAR_WRITE     = 4,
  parameter int LEN_W            = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [LEN_W-1:0]                             row_len,
  input  logic [LEN_W-1:0]                             num_rows,
  input  logic                                         in_valid,
  input  logic [IF_SCRATCH_WIDTH-1:0]                  in_data,
  output logic                                         in_ready,
  input  logic                                         IF_full,
  output logic                                         IF_wen,
  output logic [IF_PAR_WRITE*(IF_SCRATCH_WIDTH+2)-1:0] IF_din,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         cfg_err
);

  localparam int LANE_BITS = IF_SCRATCH_WIDTH + 2;
  localparam int WORD_BITS = IF_PAR_WRITE * LANE_BITS;
  localparam int LANE_W    = (IF_PAR_WRITE > 1) ? $clog2(IF_PAR_WRITE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LEN_W-1:0]        r_row_len;
  logic [LEN_W-1:0]        r_num_rows;
  logic [LEN_W-1:0]        r_elem_cnt;
  logic [LEN_W-1:0]        r_row_cnt;
  logic [LANE_W-1:0]       r_lane_cnt;
  logic [WORD_BITS-1:0]    r_pack;
  logic                    r_last_word;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_cfg_err;

  logic                    w_in_ready;
  logic                    w_wen;
  logic                    w_load;
  logic                    w_bad_cfg;
  logic                    w_cfg_ok;
  logic                    w_accept;
  logic                    w_lane_last;
  logic                    w_elem_last;
  logic                    w_row_last;
  logic                    w_final_write;
  logic [LANE_BITS-1:0]    w_lane;

  // row_len must split into whole words so that no word straddles two rows
  assign w_cfg_ok = (row_len != '0) && (num_rows != '0) &&
                    ((row_len & LEN_W'(IF_PAR_WRITE - 1)) == '0);

  assign w_accept      = (r_state == S_FILL) && in_valid;
  assign w_lane_last   = (r_lane_cnt == LANE_W'(IF_PAR_WRITE - 1));
  assign w_elem_last   = (r_elem_cnt == r_row_len - LEN_W'(1));
  assign w_row_last    = (r_row_cnt == r_num_rows - LEN_W'(1));
  assign w_lane        = {(r_elem_cnt == '0), w_elem_last, in_data};
  assign w_final_write = (r_state == S_WRITE) && w_wen && r_last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_wen      = 1'b0;
    w_load     = 1'b0;
    w_bad_cfg  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_ok) begin
            w_next = S_FILL;
            w_load = 1'b1;
          end else begin
            w_bad_cfg = 1'b1;
          end
        end
      end
      S_FILL: begin
        w_in_ready = 1'b1;
        if (in_valid && w_lane_last) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wen = ~IF_full;
        if (w_wen) begin
          w_next = r_last_word ? S_IDLE : S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_len   <= '0;
      r_num_rows  <= '0;
      r_elem_cnt  <= '0;
      r_row_cnt   <= '0;
      r_lane_cnt  <= '0;
      r_pack      <= '0;
      r_last_word <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= w_final_write;
      r_cfg_err <= w_bad_cfg;

      if (w_load) begin
        r_row_len   <= row_len;
        r_num_rows  <= num_rows;
        r_elem_cnt  <= '0;
        r_row_cnt   <= '0;
        r_lane_cnt  <= '0;
        r_last_word <= 1'b0;
        r_busy      <= 1'b1;
      end

      if (w_accept) begin
        for (int k = 0; k < IF_PAR_WRITE; k++) begin
          if (r_lane_cnt == LANE_W'(k)) begin
            r_pack[k*LANE_BITS +: LANE_BITS] <= w_lane;
          end
        end
        // wrapping here leaves the lane counter at 0 when FILL resumes after WRITE
        r_lane_cnt <= w_lane_last ? '0 : r_lane_cnt + LANE_W'(1);
        if (w_elem_last) begin
          r_elem_cnt <= '0;
          r_row_cnt  <= r_row_cnt + LEN_W'(1);
        end else begin
          r_elem_cnt <= r_elem_cnt + LEN_W'(1);
        end
        if (w_lane_last) begin
          r_last_word <= w_elem_last && w_row_last;
        end
      end

      if (w_final_write) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign in_ready = w_in_ready;
  assign IF_wen   = w_wen;
  assign IF_din   = r_pack;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_if_row_packer.sv
// tb/tb_if_row_packer.sv - directed vector bench for if_row_packer
// Job table plus hand sequences for start-while-busy and mid-job reset.
module tb_if_row_packer;

  localparam int W   = 16;
  localparam int PAR = 4;
  localparam int LB  = W + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       row_len;
  logic [7:0]       num_rows;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             IF_full;
  logic             IF_wen;
  logic [PAR*LB-1:0] IF_din;
  logic             busy;
  logic             done;
  logic             cfg_err;

  if_row_packer #(.IF_SCRATCH_WIDTH(W), .IF_PAR_WRITE(PAR), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .IF_full(IF_full), .IF_wen(IF_wen), .IF_din(IF_din),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    rl;
    int    nr;
    int    full_cycles;
    bit    gaps;
    bit    exp_err;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  int last_wr_cyc;
  int done_cyc;
  int done_cnt;
  int cfg_cnt;
  logic done_busy;
  logic [PAR*LB-1:0] wr_q[$];
  bit [6:0] pat = 7'b1011001;  // in_valid per cycle, bit 0 first: 1,0,0,1,1,0,1

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] exp_lane(input int i, input int rl);
    int p;
    p = i % rl;
    return {(p == 0), (p == rl - 1), W'(i + 1)};
  endfunction

  function automatic logic [PAR*LB-1:0] exp_word(input int w, input int rl);
    logic [PAR*LB-1:0] r;
    r = '0;
    for (int k = 0; k < PAR; k++) r[k*LB +: LB] = exp_lane(w*PAR + k, rl);
    return r;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (IF_wen) begin
      wr_q.push_back(IF_din);
      last_wr_cyc = cyc_cnt;
      chk("wen_while_full", 72'(IF_full), 72'(0));
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc_cnt;
      done_busy = busy;
    end
    if (cfg_err) cfg_cnt++;
  end

  task automatic clear_obs();
    wr_q.delete();
    done_cnt    = 0;
    cfg_cnt     = 0;
    last_wr_cyc = -10;
    done_cyc    = -1;
    done_busy   = 1'bx;
  endtask

  task automatic do_start(input int rl, input int nr);
    row_len  = 8'(rl);
    num_rows = 8'(nr);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int first, input int cnt, input int rl, input bit gaps, input int full_cycles);
    int idx;
    int cyc;
    logic v;
    logic acc;
    idx = first;
    cyc = 0;
    while (idx < first + cnt && cyc < 300) begin
      v        = gaps ? pat[cyc % 7] : 1'b1;
      in_valid = v;
      in_data  = W'(idx + 1);
      @(negedge clk);
      acc = v && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (gaps && idx == 3) chk("no_partial_write", 72'(wr_q.size()), 72'(0));
        if (full_cycles > 0 && idx == PAR) begin
          in_valid = 1'b0;
          for (int c = 0; c < full_cycles; c++) begin
            @(negedge clk);
            chk("bp_wen_low", 72'(IF_wen), 72'(0));
            chk("bp_ready_low", 72'(in_ready), 72'(0));
            chk("bp_din_held", IF_din, exp_word(0, rl));
            @(posedge clk); #1;
          end
          IF_full = 1'b0;
          @(negedge clk);
          chk("bp_release_wen", 72'(IF_wen), 72'(1));
          chk("bp_release_ready", 72'(in_ready), 72'(0));
          @(posedge clk); #1;
        end
      end
    end
    in_valid = 1'b0;
    chk("feed_complete", 72'(idx), 72'(first + cnt));
  endtask

  task automatic finish_job(input int rl, input int nr);
    int nwords;
    nwords = rl * nr / PAR;
    repeat (12) begin @(posedge clk); #1; end
    chk("done_pulses", 72'(done_cnt), 72'(1));
    chk("done_after_last_write", 72'(done_cyc), 72'(last_wr_cyc + 1));
    chk("busy_in_done_cycle", 72'(done_busy), 72'(0));
    chk("busy_after_job", 72'(busy), 72'(0));
    chk("word_count", 72'(wr_q.size()), 72'(nwords));
    for (int w = 0; w < nwords && w < wr_q.size(); w++) begin
      chk($sformatf("word%0d", w), wr_q[w], exp_word(w, rl));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"basic",        8, 2, 0, 1'b0, 1'b0};
    vecs[1] = '{"backpressure", 8, 2, 5, 1'b0, 1'b0};
    vecs[2] = '{"stalled",      4, 1, 0, 1'b1, 1'b0};
    vecs[3] = '{"bad_len6",     6, 1, 0, 1'b0, 1'b1};
    vecs[4] = '{"bad_len0",     0, 2, 0, 1'b0, 1'b1};
    vecs[5] = '{"bad_rows0",    8, 0, 0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; row_len = '0; num_rows = '0;
    in_valid = 1'b0; in_data = '0; IF_full = 1'b0;
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    chk("rst_wen", 72'(IF_wen), 72'(0));
    chk("rst_din", IF_din, 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_cfg_err", 72'(cfg_err), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      clear_obs();
      IF_full = (vecs[i].full_cycles > 0);
      do_start(vecs[i].rl, vecs[i].nr);
      #1;
      if (vecs[i].exp_err) begin
        chk({vecs[i].name, "_cfg_err"}, 72'(cfg_err), 72'(1));
        chk({vecs[i].name, "_busy"}, 72'(busy), 72'(0));
        repeat (4) begin @(posedge clk); #1; end
        chk({vecs[i].name, "_cfg_err_once"}, 72'(cfg_cnt), 72'(1));
        chk({vecs[i].name, "_no_write"}, 72'(wr_q.size()), 72'(0));
        chk({vecs[i].name, "_no_done"}, 72'(done_cnt), 72'(0));
        chk({vecs[i].name, "_idle_ready"}, 72'(in_ready), 72'(0));
      end else begin
        chk({vecs[i].name, "_fill_ready"}, 72'(in_ready), 72'(1));
        chk({vecs[i].name, "_busy"}, 72'(busy), 72'(1));
        feed(0, vecs[i].rl * vecs[i].nr, vecs[i].rl, vecs[i].gaps, vecs[i].full_cycles);
        finish_job(vecs[i].rl, vecs[i].nr);
        chk({vecs[i].name, "_no_cfg_err"}, 72'(cfg_cnt), 72'(0));
        if (i == 0 && wr_q.size() >= 3) begin
          chk("w0_lane0", 72'(wr_q[0][17:0]), 72'(18'h20001));
          chk("w0_lane1", 72'(wr_q[0][35:18]), 72'(18'h00002));
          chk("w1_lane3", 72'(wr_q[1][71:54]), 72'(18'h10008));
          chk("w2_lane0", 72'(wr_q[2][17:0]), 72'(18'h20009));
        end
      end
      IF_full = 1'b0;
    end

    // start while busy must not disturb the running row_len 8 job
    clear_obs();
    do_start(8, 2);
    feed(0, 2, 8, 1'b0, 0);
    do_start(16, 1);
    feed(2, 14, 8, 1'b0, 0);
    finish_job(8, 2);
    chk("busy_start_no_cfg_err", 72'(cfg_cnt), 72'(0));

    // mid-job reset, then a fresh one-word job
    clear_obs();
    do_start(8, 2);
    feed(0, 2, 8, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 72'(in_ready), 72'(0));
    chk("mid_rst_wen", 72'(IF_wen), 72'(0));
    chk("mid_rst_din", IF_din, 72'(0));
    chk("mid_rst_busy", 72'(busy), 72'(0));
    chk("mid_rst_done", 72'(done), 72'(0));
    chk("mid_rst_cfg_err", 72'(cfg_err), 72'(0));
    @(posedge clk); #1;
    clear_obs();
    do_start(4, 1);
    feed(0, 4, 4, 1'b0, 0);
    finish_job(4, 1);
    if (wr_q.size() >= 1) begin
      chk("post_rst_lane0", 72'(wr_q[0][17:0]), 72'(18'h20001));
      chk("post_rst_lane3", 72'(wr_q[0][71:54]), 72'(18'h10004));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
